// File: rtl/proc_alu.sv
// proc_alu: operand register A and result register G for the base processor.
// A is latched from buswires; G <= A +/- buswires on a later edge.
// Optional macro ALU_FLAGS_EN adds registered flag_z/flag_n/flag_c/flag_v.
module proc_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ain,
  input  logic             gin,
  input  logic             sub,
  input  logic [WIDTH-1:0] buswires,
`ifdef ALU_FLAGS_EN
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
`endif
  output logic [WIDTH-1:0] aluout
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] result_c;

`ifdef ALU_FLAGS_EN
  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH:0]   wide_c;
  logic             z_c;
  logic             n_c;
  logic             c_c;
  logic             v_c;

  // Single adder: subtract as A + ~bus + 1 so the carry out is NOT borrow
  always_comb begin
    b_eff_c  = sub ? ~buswires : buswires;
    wide_c   = {1'b0, a_q} + {1'b0, b_eff_c} + (WIDTH+1)'(sub);
    result_c = wide_c[WIDTH-1:0];
    z_c      = (result_c == '0);
    n_c      = result_c[WIDTH-1];
    c_c      = wide_c[WIDTH];
    v_c      = (a_q[WIDTH-1] == b_eff_c[WIDTH-1]) &&
               (result_c[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Flag registers load alongside G
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (gin) begin
      flag_z <= z_c;
      flag_n <= n_c;
      flag_c <= c_c;
      flag_v <= v_c;
    end
  end
`else
  // Modulo-2^WIDTH add or subtract; carry/borrow discarded
  always_comb begin
    result_c = sub ? (a_q - buswires) : (a_q + buswires);
  end
`endif

  // Operand register A
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_q <= '0;
    end else if (ain) begin
      a_q <= buswires;
    end
  end

  // Result register G; uses the pre-edge A when ain and gin coincide
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      g_q <= '0;
    end else if (gin) begin
      g_q <= result_c;
    end
  end

  assign aluout = g_q;

endmodule

// File: tb/tb_proc_alu.sv
// Directed testbench for proc_alu (build with +define+ALU_FLAGS_EN to cover flags).
`timescale 1ns/1ps
module tb_proc_alu;

  localparam int unsigned WIDTH = 16;

  logic             clock;
  logic             resetn;
  logic             ain;
  logic             gin;
  logic             sub;
  logic [WIDTH-1:0] buswires;
  logic [WIDTH-1:0] aluout;
`ifdef ALU_FLAGS_EN
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
`endif

  int checks;
  int errors;

  proc_alu #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .ain      (ain),
    .gin      (gin),
    .sub      (sub),
    .buswires (buswires),
`ifdef ALU_FLAGS_EN
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_c   (flag_c),
    .flag_v   (flag_v),
`endif
    .aluout   (aluout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one edge with the given controls, then sample 1 ns after it
  task automatic step(input logic a_en, input logic g_en, input logic s,
                      input logic [WIDTH-1:0] bus);
    ain      = a_en;
    gin      = g_en;
    sub      = s;
    buswires = bus;
    @(posedge clock);
    #1;
    ain = 1'b0;
    gin = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (aluout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_initial: aluout=%h expected=%h", aluout, 16'h0000);
    end
    resetn = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'h0100);
    step(1'b0, 1'b1, 1'b0, 16'h0023);
    checks++;
    if (aluout !== 16'h0123) begin
      errors++;
      $display("FAIL reset_preload: aluout=%h expected=%h", aluout, 16'h0123);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (aluout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: aluout=%h expected=%h", aluout, 16'h0000);
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++;
    if (aluout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: aluout=%h expected=%h", aluout, 16'h0000);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0005);
    checks++;
    if (aluout !== 16'h0005) begin
      errors++;
      $display("FAIL reset_a_cleared: aluout=%h expected=%h", aluout, 16'h0005);
    end
  endtask

  task automatic test_add();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
    step(1'b1, 1'b0, 1'b0, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 16'h0F0F);
    checks++;
    if (aluout !== 16'h2143) begin
      errors++;
      $display("FAIL add_directed: aluout=%h expected=%h", aluout, 16'h2143);
    end
    for (int i = 0; i < 5; i++) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      exp = a + b;
      step(1'b1, 1'b0, 1'b1, a);
      step(1'b0, 1'b1, 1'b0, b);
      checks++;
      if (aluout !== exp) begin
        errors++;
        $display("FAIL add_rand%0d: %h+%h aluout=%h expected=%h", i, a, b, aluout, exp);
      end
    end
  endtask

  task automatic test_sub();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
    step(1'b1, 1'b0, 1'b0, 16'h0010);
    step(1'b0, 1'b1, 1'b1, 16'h0020);
    checks++;
    if (aluout !== 16'hFFF0) begin
      errors++;
      $display("FAIL sub_directed: aluout=%h expected=%h", aluout, 16'hFFF0);
    end
    for (int i = 0; i < 5; i++) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      exp = a - b;
      step(1'b1, 1'b0, 1'b0, a);
      step(1'b0, 1'b1, 1'b1, b);
      checks++;
      if (aluout !== exp) begin
        errors++;
        $display("FAIL sub_rand%0d: %h-%h aluout=%h expected=%h", i, a, b, aluout, exp);
      end
    end
  endtask

  task automatic test_wrap_hold();
    step(1'b1, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 16'h0001);
    checks++;
    if (aluout !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_add: aluout=%h expected=%h", aluout, 16'h0000);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'(i % 2), WIDTH'(16'h5A5A + i));
      checks++;
      if (aluout !== 16'h0000) begin
        errors++;
        $display("FAIL hold_cycle%0d: aluout=%h expected=%h", i, aluout, 16'h0000);
      end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b0, 16'h0003);
    step(1'b1, 1'b1, 1'b0, 16'h0004);
    checks++;
    if (aluout !== 16'h0007) begin
      errors++;
      $display("FAIL simul_load: aluout=%h expected=%h", aluout, 16'h0007);
    end
    step(1'b0, 1'b1, 1'b0, 16'h0001);
    checks++;
    if (aluout !== 16'h0005) begin
      errors++;
      $display("FAIL simul_next: aluout=%h expected=%h", aluout, 16'h0005);
    end
  endtask

`ifdef ALU_FLAGS_EN
  task automatic test_flags();
    step(1'b1, 1'b0, 1'b0, 16'h7FFF);
    step(1'b0, 1'b1, 1'b0, 16'h0001);
    checks++;
    if ({aluout, flag_z, flag_n, flag_c, flag_v} !== {16'h8000, 4'b0101}) begin
      errors++;
      $display("FAIL flags_ovf: aluout=%h zncv=%b%b%b%b expected=8000 zncv=0101",
               aluout, flag_z, flag_n, flag_c, flag_v);
    end
    step(1'b1, 1'b0, 1'b0, 16'h0005);
    step(1'b0, 1'b1, 1'b1, 16'h0005);
    checks++;
    if ({aluout, flag_z, flag_n, flag_c, flag_v} !== {16'h0000, 4'b1010}) begin
      errors++;
      $display("FAIL flags_zero: aluout=%h zncv=%b%b%b%b expected=0000 zncv=1010",
               aluout, flag_z, flag_n, flag_c, flag_v);
    end
    step(1'b0, 1'b0, 1'b0, 16'h7FFF);
    checks++;
    if ({flag_z, flag_n, flag_c, flag_v} !== 4'b1010) begin
      errors++;
      $display("FAIL flags_hold: zncv=%b%b%b%b expected=1010",
               flag_z, flag_n, flag_c, flag_v);
    end
  endtask
`endif

  // Bounded run time in case the flow stalls
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    resetn   = 1'b0;
    ain      = 1'b0;
    gin      = 1'b0;
    sub      = 1'b0;
    buswires = '0;
    test_reset();
    test_add();
    test_sub();
    test_wrap_hold();
    test_back_to_back();
`ifdef ALU_FLAGS_EN
    test_flags();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
